// File: rtl/ir_queue.sv
// ir_queue: a FIFO of up to DEPTH fetched LC-3b instruction words with
// valid/ready handshakes on both sides. The head entry is decoded into the
// standard instruction fields. This lets fetch run ahead of execute.
//
// Ports:
//   clk, reset_n         rising-edge clock, synchronous active-low reset
//   flush                discard every entry (taken branch, JSR/JSRR, TRAP, RET)
//   in_valid, in         fetch side: word offered this cycle
//   in_ready             queue can accept a word (depends on held state only)
//   out_valid, out_ready decode side: head entry present / consumed
//   count                current occupancy
//   opcode .. trapvect8  fields sliced from the head word; all zero when
//                        out_valid=0
//
// Optional feature, controlled by the macro IR_QUEUE_BYPASS_EN:
//   When the macro is defined and the queue is empty, an incoming word (with
//   no flush) is shown on the outputs in the same cycle. If decode takes it
//   in that cycle, it is never written to storage.
module ir_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [15:0]      in,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [CNT_W-1:0] count,
    output logic [3:0]       opcode,
    output logic [2:0]       dest,
    output logic [2:0]       src1,
    output logic [2:0]       src2,
    output logic [5:0]       offset6,
    output logic [8:0]       offset9,
    output logic [10:0]      offset11,
    output logic             bit4,
    output logic             bit5,
    output logic             bit11,
    output logic [3:0]       imm4,
    output logic [4:0]       imm5,
    output logic [7:0]       trapvect8
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [15:0]      mem_q [DEPTH];
    logic [15:0]      mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic        bypass;
    logic        push;
    logic        write_en;
    logic        pop_mem;
    logic [15:0] head_word;

    always_comb begin
        bypass = 1'b0;
`ifdef IR_QUEUE_BYPASS_EN
        bypass = (count_q == '0) && in_valid && !flush;
`endif
    end

    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0) || bypass;
    assign count     = count_q;

    // A bypassed word that decode accepts at once is never stored.
    // pop_mem only fires when a stored entry is actually present.
    assign push     = in_valid && in_ready;
    assign write_en = push && !(bypass && out_ready);
    assign pop_mem  = out_ready && (count_q != '0);

    // Next-state logic. Pointers wrap explicitly so that a DEPTH that is not
    // a power of two still works. A flush drops any push or pop in the same
    // cycle. Stored words are left in place because they become unreachable.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (write_en) begin
                mem_d[wr_ptr_q] = in;
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop_mem) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({write_en, pop_mem})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 16'h0000;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // The head is forced to zero when nothing is valid, so stale storage
    // never reaches decode.
    always_comb begin
        head_word = 16'h0000;
        if (bypass) begin
            head_word = in;
        end else if (count_q != '0) begin
            head_word = mem_q[rd_ptr_q];
        end
    end

    assign opcode    = head_word[15:12];
    assign dest      = head_word[11:9];
    assign src1      = head_word[8:6];
    assign src2      = head_word[2:0];
    assign offset6   = head_word[5:0];
    assign offset9   = head_word[8:0];
    assign offset11  = head_word[10:0];
    assign bit4      = head_word[4];
    assign bit5      = head_word[5];
    assign bit11     = head_word[11];
    assign imm4      = head_word[3:0];
    assign imm5      = head_word[4:0];
    assign trapvect8 = head_word[7:0];

endmodule

// File: tb/tb_ir_queue.sv
// tb_ir_queue: randomized and directed stimulus for ir_queue (DEPTH=4).
// A queue-based reference model predicts the outputs. A compare process checks
// every cycle, and literal expectations from the instruction encodings anchor
// the model. The IR_QUEUE_BYPASS_EN macro must match the RTL build.
module tb_ir_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef IR_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic [15:0]      in_word = 16'h0;
    logic             in_ready;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [CNT_W-1:0] count;
    logic [3:0]       opcode;
    logic [2:0]       dest, src1, src2;
    logic [5:0]       offset6;
    logic [8:0]       offset9;
    logic [10:0]      offset11;
    logic             bit4, bit5, bit11;
    logic [3:0]       imm4;
    logic [4:0]       imm5;
    logic [7:0]       trapvect8;

    int  compared = 0;
    int  mismatched = 0;
    bit  check_en = 1'b0;
    logic [15:0] model_q[$];

    ir_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in(in_word), .in_ready(in_ready),
        .out_ready(out_ready), .out_valid(out_valid), .count(count),
        .opcode(opcode), .dest(dest), .src1(src1), .src2(src2),
        .offset6(offset6), .offset9(offset9), .offset11(offset11),
        .bit4(bit4), .bit5(bit5), .bit11(bit11),
        .imm4(imm4), .imm5(imm5), .trapvect8(trapvect8)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [15:0] word,
                                 input logic ordy, input logic fl, input logic rn);
        @(negedge clk);
        in_valid  = iv;
        in_word   = word;
        out_ready = ordy;
        flush     = fl;
        reset_n   = rn;
    endtask

    // Reference model: the entries are a plain queue, and the rules for one
    // clock cycle are applied to it.
    always @(posedge clk) begin
        bit byp_now;
        byp_now = BYP && (model_q.size() == 0) && in_valid && !flush;
        if (!reset_n || flush) begin
            model_q.delete();
        end else if (byp_now && out_ready) begin
            // The word is consumed straight from the input.
        end else begin
            bit do_pop;
            bit do_push;
            do_pop  = (model_q.size() > 0) && out_ready;
            do_push = in_valid && (model_q.size() < DEPTH);
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(in_word);
        end
    end

    // Compare every output against the model partway through each cycle.
    always @(negedge clk) begin
        #2;
        if (check_en) begin
            bit          byp_now;
            bit          exp_valid;
            logic [15:0] h;
            byp_now   = BYP && (model_q.size() == 0) && in_valid && !flush;
            exp_valid = (model_q.size() > 0) || byp_now;
            h = 16'h0;
            if (byp_now) h = in_word;
            else if (model_q.size() > 0) h = model_q[0];
            checkOutput("out_valid", 32'(out_valid), 32'(exp_valid));
            checkOutput("in_ready", 32'(in_ready), 32'(model_q.size() != DEPTH));
            checkOutput("count", 32'(count), 32'(model_q.size()));
            checkOutput("opcode", 32'(opcode), 32'(h >> 12));
            checkOutput("dest", 32'(dest), 32'((h >> 9) & 16'h7));
            checkOutput("src1", 32'(src1), 32'((h >> 6) & 16'h7));
            checkOutput("src2", 32'(src2), 32'(h & 16'h7));
            checkOutput("offset6", 32'(offset6), 32'(h & 16'h3F));
            checkOutput("offset9", 32'(offset9), 32'(h & 16'h1FF));
            checkOutput("offset11", 32'(offset11), 32'(h & 16'h7FF));
            checkOutput("bit4", 32'(bit4), 32'((h >> 4) & 16'h1));
            checkOutput("bit5", 32'(bit5), 32'((h >> 5) & 16'h1));
            checkOutput("bit11", 32'(bit11), 32'((h >> 11) & 16'h1));
            checkOutput("imm4", 32'(imm4), 32'(h & 16'hF));
            checkOutput("imm5", 32'(imm5), 32'(h & 16'h1F));
            checkOutput("trapvect8", 32'(trapvect8), 32'(h & 16'hFF));
        end
    end

    initial begin
        applyStimulus(0, 16'h0, 0, 0, 0);
        applyStimulus(0, 16'h0, 0, 0, 0);
        check_en = 1'b1;
        applyStimulus(0, 16'h0, 0, 0, 1);
        #3;
        checkOutput("reset_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_count", 32'(count), 32'd0);
        checkOutput("reset_trapvect", 32'(trapvect8), 32'd0);

        // ADD R1,R2,R3
        applyStimulus(1, 16'h1283, 0, 0, 1);
        applyStimulus(0, 16'h0, 0, 0, 1);
        #3;
        checkOutput("add_valid", 32'(out_valid), 32'd1);
        checkOutput("add_opcode", 32'(opcode), 32'h1);
        checkOutput("add_dest", 32'(dest), 32'd1);
        checkOutput("add_src1", 32'(src1), 32'd2);
        checkOutput("add_src2", 32'(src2), 32'd3);
        checkOutput("add_bit5", 32'(bit5), 32'd0);
        checkOutput("add_count", 32'(count), 32'd1);

        // Offer five words to an empty queue that is not being drained.
        applyStimulus(0, 16'h0, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 16'h1000 * (i + 1) + 16'(i), 0, 0, 1);
        applyStimulus(0, 16'h0, 0, 0, 1);
        #3;
        checkOutput("full_count", 32'(count), 32'd4);
        checkOutput("full_ready", 32'(in_ready), 32'd0);
        checkOutput("full_head", 32'(opcode), 32'h1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 16'h0, 1, 0, 1);
            #3;
            checkOutput("drain_order", 32'(opcode), 32'(i + 1));
        end
        applyStimulus(0, 16'h0, 0, 0, 1);
        #3;
        checkOutput("drained_valid", 32'(out_valid), 32'd0);
        checkOutput("drained_count", 32'(count), 32'd0);

        // Run a steady push-and-pop stream at occupancy 2 so the pointers wrap.
        applyStimulus(1, 16'h0001, 0, 0, 1);
        applyStimulus(1, 16'h0002, 0, 0, 1);
        for (int i = 0; i < 10; i++) applyStimulus(1, 16'h0003 + 16'(i), 1, 0, 1);
        applyStimulus(0, 16'h0, 0, 0, 1);
        #3;
        checkOutput("steady_count", 32'(count), 32'd2);
        checkOutput("steady_head", 32'(imm5), 32'd11);

        // TRAP x25
        applyStimulus(0, 16'h0, 0, 0, 0);
        applyStimulus(1, 16'hF025, 0, 0, 1);
        applyStimulus(0, 16'h0, 0, 0, 1);
        #3;
        checkOutput("trap_vect", 32'(trapvect8), 32'h25);
        checkOutput("trap_opcode", 32'(opcode), 32'hF);
        applyStimulus(0, 16'h0, 1, 0, 1);
        applyStimulus(0, 16'h0, 0, 0, 1);
        #3;
        checkOutput("trap_after_valid", 32'(out_valid), 32'd0);
        checkOutput("trap_after_vect", 32'(trapvect8), 32'd0);

        // Fill the queue to three entries, then flush while a word is offered.
        for (int i = 0; i < 3; i++) applyStimulus(1, 16'h2000 + 16'(i), 0, 0, 1);
        applyStimulus(1, 16'h3333, 0, 1, 1);
        applyStimulus(0, 16'h0, 0, 0, 1);
        #3;
        checkOutput("flush_count", 32'(count), 32'd0);
        checkOutput("flush_valid", 32'(out_valid), 32'd0);
        checkOutput("flush_ready", 32'(in_ready), 32'd1);

        // Reset while the queue is full.
        for (int i = 0; i < 4; i++) applyStimulus(1, 16'hABCD, 0, 0, 1);
        applyStimulus(0, 16'h0, 0, 0, 0);
        applyStimulus(0, 16'h0, 0, 0, 1);
        #3;
        checkOutput("rst_full_count", 32'(count), 32'd0);
        checkOutput("rst_full_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_full_offset11", 32'(offset11), 32'd0);

`ifdef IR_QUEUE_BYPASS_EN
        // JSR with bypass: the word is visible and consumed in the same cycle.
        applyStimulus(1, 16'h4802, 1, 0, 1);
        #3;
        checkOutput("byp_opcode", 32'(opcode), 32'h4);
        checkOutput("byp_bit11", 32'(bit11), 32'd1);
        checkOutput("byp_offset11", 32'(offset11), 32'h002);
        checkOutput("byp_valid", 32'(out_valid), 32'd1);
        applyStimulus(0, 16'h0, 0, 0, 1);
        #3;
        checkOutput("byp_count", 32'(count), 32'd0);
`endif

        // Randomized traffic, including occasional flushes and resets.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 99) < 65, 16'($urandom),
                          $urandom_range(0, 99) < 50,
                          $urandom_range(0, 99) < 3,
                          $urandom_range(0, 99) >= 1);
        end
        applyStimulus(0, 16'h0, 0, 0, 1);
        @(negedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ir_queue.md
Name: ir_queue

Overview:
- Parametrised successor to the single-entry instruction register. Buffers up to DEPTH fetched LC-3b instruction words in a FIFO with valid/ready handshakes.
- Decodes the head entry into the standard instruction fields: opcode, registers, offsets, immediates, flag bits and trap vector.
- Sits between instruction fetch (memory read data) and the control/datapath decode, so fetch can run ahead of execute.
- Supports a flush for taken branches, JSR/JSRR, TRAP and RET.

Parameters:
- DEPTH, 4, number of instruction entries; legal range 2..16; any value, not restricted to powers of two.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count; derived, never overridden.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- flush  in  1  discard all entries this cycle
- in_valid  in  1  fetch presents a word on in
- in  in  16  instruction word (lc3b_word)
- in_ready  out  1  queue can accept a word
- out_ready  in  1  decode consumes the head entry
- out_valid  out  1  head entry valid
- count  out  CNT_W  current occupancy
- opcode  out  4  head[15:12] (lc3b_opcode)
- dest  out  3  head[11:9]
- src1  out  3  head[8:6]
- src2  out  3  head[2:0]
- offset6  out  6  head[5:0]
- offset9  out  9  head[8:0]
- offset11  out  11  head[10:0]
- bit4, bit5, bit11  out  1 each  head[4], head[5], head[11]
- imm4  out  4  head[3:0]
- imm5  out  5  head[4:0]
- trapvect8  out  8  head[7:0]

Behaviour:
- Reset (reset_n=0 at posedge clk):
  - read pointer, write pointer and count go to 0; all storage entries are cleared to 16'h0000.
  - After reset: out_valid=0, in_ready=1, count=0, every decoded field 0.
- Reset has priority over flush, push and pop. Reset asserted mid-burst discards all contents with no partial completion.
- push = in_valid & in_ready. in_ready = (count != DEPTH). in_ready is registered-state only and never depends on out_ready, so there is no pop-to-push combinational path.
- pop = out_valid & out_ready. out_valid = (count != 0).
- Storage write and pointer update happen at posedge on push; the read pointer advances on pop.
- Pointers increment modulo DEPTH: at DEPTH-1 they wrap to 0 explicitly, with no reliance on power-of-two overflow.
- count update:
  - push only: +1
  - pop only: -1
  - push and pop in the same cycle, legal only when not full: unchanged
  - neither: unchanged
- Full (count=DEPTH): in_ready=0; in_valid is ignored and the word is not captured.
- Empty (count=0): out_ready is ignored; count never underflows.
- Latency:
  - a word pushed at edge N appears at the head and raises out_valid after edge N, i.e. 1 cycle.
  - if the queue is already non-empty, the word appears once older entries drain, in strict FIFO order.
- Decoded fields:
  - purely combinational slices of the entry at the read pointer.
  - when out_valid=0, all fields are forced to 0 and never expose stale storage.
  - opcode is cast to lc3b_opcode.
- flush=1 at posedge: pointers and count return to 0; a push or pop in the same cycle is dropped. Storage contents need not be cleared.
- After flush: out_valid=0 and in_ready=1 from the next cycle.

Optional Feature:
- Macro: IR_QUEUE_BYPASS_EN.
- Defined:
  - when count=0, in_valid=1 and flush=0, out_valid=1 in the same cycle and the decoded fields present in directly (combinational bypass).
  - if out_ready=1 that cycle, the word is consumed without being written and count stays 0.
  - if out_ready=0, the word is written normally and count becomes 1.
- Undefined: no bypass; 1-cycle minimum latency as specified above.

Test Plan:
- Reset then push 16'h1283 (ADD R1,R2,R3): next cycle out_valid=1, opcode=4'h1, dest=1, src1=2, src2=3, bit5=0, count=1.
- Push 5 words with DEPTH=4 and out_ready=0: first 4 accepted, in_ready=0 with count=4, 5th word not stored. Pop 4 words: they come out in push order, then out_valid=0 and count=0.
- Simultaneous push and pop at count=2 for 10 cycles: count stays 2, pointers wrap past DEPTH-1, output order is preserved.
- Push 16'hF025 (TRAP x25) then pop: trapvect8=8'h25 while valid. After the pop all fields read 0 and out_valid=0.
- Fill to 3 entries, then assert flush together with in_valid=1: next cycle count=0, out_valid=0, the flushed-cycle word is absent, in_ready=1.
- reset_n=0 for one cycle while the queue is full: next cycle count=0, in_ready=1, all fields 0. With IR_QUEUE_BYPASS_EN defined, push 16'h4802 to an empty queue with out_ready=1: same-cycle opcode=4'h4, bit11=1, offset11=11'h002, count remains 0.
